// File: rtl/uart_link_pkg.sv
// -----------------------------------------------------------------------------
// uart_link_pkg
// Shared definitions for the board-to-board serial link (transmit and receive
// sides): frame geometry, line levels, bit-in-character counter width and the
// transmit state encoding.
// -----------------------------------------------------------------------------
package uart_link_pkg;

    localparam int   FRAME_BITS = 10;    // start + 8 data + stop
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam int   BIC_W      = 4;     // holds 0..FRAME_BITS

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

    // Frame image as loaded into the transmit shifter; bit 0 leaves first.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data);
        return {STOP_BIT, data, START_BIT};
    endfunction

endpackage

// File: rtl/bit_timer.sv
// -----------------------------------------------------------------------------
// bit_timer
// Counts clk cycles 0..CLKS_PER_BIT-1 while enabled and flags the terminal
// count. Used by the transmitter for bit periods and by the receiver for
// mid-bit sampling.
//
// Ports:
//   clk    : system clock
//   reset  : asynchronous, active-high reset (count to 0)
//   clear  : synchronous clear of the count (takes priority over enable)
//   enable : advance the count this cycle
//   tick   : high during the terminal-count cycle while enabled
// -----------------------------------------------------------------------------
module bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count_reg;

    assign tick = enable && (count_reg == TERMINAL);

    // Wrapping at terminal count keeps the counter inside its range, so the
    // minimal $clog2 width never overflows.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= tick ? '0 : count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/uart_frame_sender.sv
// -----------------------------------------------------------------------------
// uart_frame_sender
// Serial transmit stage for the board-to-board link. A byte is captured into a
// holding register on load; transmit (sampled in IDLE) sends one 10-bit frame:
// start 0, data LSB first, stop 1, each bit held CLKS_PER_BIT cycles.
//
// Ports:
//   clk        : system clock
//   reset      : asynchronous, active-high reset
//   load       : capture data_in into the holding register
//   data_in    : byte to send
//   transmit   : start a frame (ignored while a frame is in flight)
//   serial_out : serial line, idles high, driven straight from a flop
//   bic        : bit-in-character, 0 in IDLE, 1..10 while sending bit 0..9
//   busy       : high while a frame is in flight
//   done       : one-cycle pulse on the last clk of the stop bit
// -----------------------------------------------------------------------------
module uart_frame_sender
    import uart_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [7:0]       data_in,
    input  logic             transmit,
    output logic             serial_out,
    output logic [BIC_W-1:0] bic,
    output logic             busy,
    output logic             done
);

    localparam logic [BIC_W-1:0] LAST_BIC = BIC_W'(FRAME_BITS);

    tx_state_t             state_reg, state_next;
    logic [7:0]            hold_reg,  hold_next;
    logic [FRAME_BITS-1:0] shift_reg, shift_next;
    logic [BIC_W-1:0]      bic_reg,   bic_next;
    logic                  tick;

    // Timer is held at zero in IDLE so every frame starts on a fresh period.
    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_reg == IDLE),
        .enable (state_reg == SEND),
        .tick   (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            hold_reg  <= 8'h00;
            shift_reg <= '1;
            bic_reg   <= '0;
        end else begin
            state_reg <= state_next;
            hold_reg  <= hold_next;
            shift_reg <= shift_next;
            bic_reg   <= bic_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        bic_next   = bic_reg;
        hold_next  = load ? data_in : hold_reg;
        done       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (transmit) begin
                    state_next = SEND;
                    // Same-cycle load bypasses the holding register.
                    shift_next = build_frame(load ? data_in : hold_reg);
                    bic_next   = BIC_W'(1);
                end
            end
            SEND: begin
                if (tick) begin
                    // Fill with stop level: after the last shift the line sits high.
                    shift_next = {STOP_BIT, shift_reg[FRAME_BITS-1:1]};
                    if (bic_reg == LAST_BIC) begin
                        state_next = IDLE;
                        bic_next   = '0;
                        done       = 1'b1;
                    end else begin
                        bic_next = bic_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The shifter LSB is a flop output, so the line has no combinational path.
    assign serial_out = shift_reg[0];
    assign bic        = bic_reg;
    assign busy       = (state_reg == SEND);

endmodule

// File: tb/tb_uart_frame_sender.sv
module tb_uart_frame_sender;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [7:0] data_in;
    logic       transmit;

    logic       serial_out, busy, done;
    logic [3:0] bic;
    logic       s16_serial_out, s16_busy, s16_done;
    logic [3:0] s16_bic;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_frame_sender #(.CLKS_PER_BIT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .data_in    (data_in),
        .transmit   (transmit),
        .serial_out (serial_out),
        .bic        (bic),
        .busy       (busy),
        .done       (done)
    );

    uart_frame_sender dut16 (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .data_in    (data_in),
        .transmit   (transmit),
        .serial_out (s16_serial_out),
        .bic        (s16_bic),
        .busy       (s16_busy),
        .done       (s16_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called on frame cycle 1 (one clk after transmit was sampled). Walks the
    // 40 cycles of a CLKS_PER_BIT=4 frame, optionally pulsing load at cycle
    // load_k, then checks the idle cycle that follows.
    task automatic check_frame(input string tag, input logic [7:0] b,
                               input int load_k, input logic [7:0] load_val,
                               output int done_abs);
        logic [9:0] exp_line;
        logic [9:0] obs_line;
        bit         line_ok;
        bit         bic_ok;
        int         dones;
        int         done_k;
        exp_line = {1'b1, b, 1'b0};
        obs_line = '0;
        line_ok  = 1'b1;
        bic_ok   = 1'b1;
        dones    = 0;
        done_k   = -1;
        done_abs = -1;
        for (int k = 1; k <= 40; k++) begin
            int bi;
            bi = (k - 1) / 4;
            if (serial_out !== exp_line[bi]) line_ok = 1'b0;
            if (bic !== 4'(bi + 1) || busy !== 1'b1) bic_ok = 1'b0;
            if (k % 4 == 2) obs_line[bi] = serial_out;
            if (done === 1'b1) begin
                dones++;
                done_k   = k;
                done_abs = cyc;
            end
            if (k == load_k) begin
                load    = 1'b1;
                data_in = load_val;
            end else if (k == load_k + 1) begin
                load    = 1'b0;
                data_in = 'x;
            end
            if (k < 40) step();
        end
        chk({tag, "_line"},      32'(obs_line), 32'(exp_line));
        chk({tag, "_line_held"}, 32'(line_ok),  32'd1);
        chk({tag, "_bic_busy"},  32'(bic_ok),   32'd1);
        chk({tag, "_done_cnt"},  32'(dones),    32'd1);
        chk({tag, "_done_cyc"},  32'(done_k),   32'd40);
        step();
        chk({tag, "_end_busy"},  32'(busy),       32'd0);
        chk({tag, "_end_bic"},   32'(bic),        32'd0);
        chk({tag, "_end_line"},  32'(serial_out), 32'd1);
        chk({tag, "_end_done"},  32'(done),       32'd0);
    endtask

    initial begin
        int d1, d2, dx;
        int low_n, pat_ok, done16_k;

        reset    = 1'b1;
        load     = 1'b0;
        data_in  = 8'h00;
        transmit = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_line", 32'(serial_out), 32'd1);
        chk("rst_bic",  32'(bic),        32'd0);
        chk("rst_busy", 32'(busy),       32'd0);
        chk("rst_done", 32'(done),       32'd0);
        chk("rst16_line", 32'(s16_serial_out), 32'd1);
        reset = 1'b0;
        step();
        chk("idle_line", 32'(serial_out), 32'd1);

        // Basic frame 8'hA5
        load = 1'b1; data_in = 8'hA5;
        step();
        load = 1'b0; data_in = 'x; transmit = 1'b1;
        step();
        transmit = 1'b0;
        check_frame("a5", 8'hA5, 0, 8'h00, dx);

        // Load and transmit in the same cycle: bypass
        load = 1'b1; data_in = 8'h3C;
        step();
        load = 1'b1; data_in = 8'hF0; transmit = 1'b1;
        step();
        load = 1'b0; data_in = 'x; transmit = 1'b0;
        check_frame("bypass", 8'hF0, 0, 8'h00, dx);
        transmit = 1'b1;
        step();
        transmit = 1'b0;
        check_frame("hold_f0", 8'hF0, 0, 8'h00, dx);

        // Load during SEND (cycle 13 is bic=4)
        load = 1'b1; data_in = 8'h55;
        step();
        load = 1'b0; data_in = 'x; transmit = 1'b1;
        step();
        transmit = 1'b0;
        check_frame("ld_send", 8'h55, 13, 8'hFF, dx);
        transmit = 1'b1;
        step();
        transmit = 1'b0;
        check_frame("after_ld", 8'hFF, 0, 8'h00, dx);

        // Held transmit: two frames, one idle clk apart
        load = 1'b1; data_in = 8'h81;
        step();
        load = 1'b0; data_in = 'x; transmit = 1'b1;
        step();
        check_frame("held1", 8'h81, 0, 8'h00, d1);
        step();
        transmit = 1'b0;
        check_frame("held2", 8'h81, 0, 8'h00, d2);
        chk("held_done_gap", 32'(d2 - d1), 32'd41);

        // Reset mid-frame, then send with no reload
        load = 1'b1; data_in = 8'hA5;
        step();
        load = 1'b0; data_in = 'x; transmit = 1'b1;
        step();
        transmit = 1'b0;
        repeat (12) step();
        chk("mid_bic",  32'(bic),  32'd4);
        chk("mid_busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_line", 32'(serial_out), 32'd1);
        chk("arst_bic",  32'(bic),        32'd0);
        chk("arst_busy", 32'(busy),       32'd0);
        step();
        reset = 1'b0;
        step();
        transmit = 1'b1;
        step();
        transmit = 1'b0;
        check_frame("rst_zero", 8'h00, 0, 8'h00, dx);

        // Default CLKS_PER_BIT=16, byte 8'h00
        reset = 1'b1;
        step();
        reset = 1'b0;
        load = 1'b1; data_in = 8'h00;
        step();
        load = 1'b0; data_in = 'x; transmit = 1'b1;
        step();
        transmit = 1'b0;
        low_n    = 0;
        pat_ok   = 1;
        done16_k = -1;
        for (int k = 1; k <= 160; k++) begin
            if (s16_serial_out === 1'b0) low_n++;
            if (s16_serial_out !== ((k <= 144) ? 1'b0 : 1'b1)) pat_ok = 0;
            if (s16_done === 1'b1) done16_k = k;
            if (k < 160) step();
        end
        chk("d16_low_cnt", 32'(low_n),    32'd144);
        chk("d16_pattern", 32'(pat_ok),   32'd1);
        chk("d16_done",    32'(done16_k), 32'd160);
        step();
        chk("d16_end_busy", 32'(s16_busy),       32'd0);
        chk("d16_end_line", 32'(s16_serial_out), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
